// File: rtl/sccb_init_sequencer.sv
// SCCB register-table initialisation sequencer: walks an external addr/data table
// and issues one SCCB write per entry with power-up wait, delay entries, gaps and NACK retry.
module sccb_init_sequencer #(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         NUM_REGS    = 64,
    parameter int         IDX_W       = 6,
    parameter int         POWERUP_CYC = 65536,
    parameter int         GAP_CYC     = 256,
    parameter int         DELAY_UNIT  = 1024,
    parameter int         MAX_RETRY   = 3
) (
    input  logic             pclk_i,
    input  logic             preset_i,
    input  logic             start_i,
    output logic [IDX_W-1:0] tbl_index_o,
    input  logic [7:0]       tbl_addr_i,
    input  logic [7:0]       tbl_data_i,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    output logic [7:0]       req_id_o,
    output logic [7:0]       req_addr_o,
    output logic [7:0]       req_data_o,
    input  logic             xfer_done_i,
    input  logic             xfer_nack_i,
    output logic             busy_o,
    output logic             init_done_o,
    output logic             init_err_o,
    output logic [IDX_W-1:0] err_index_o
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PWRUP = 4'd1;
    localparam logic [3:0] S_FETCH = 4'd2;
    localparam logic [3:0] S_ISSUE = 4'd3;
    localparam logic [3:0] S_WAIT  = 4'd4;
    localparam logic [3:0] S_GAP   = 4'd5;
    localparam logic [3:0] S_DELAY = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;

    // One down-counter serves power-up, gap and delay; sized for the largest of the three.
    localparam int DLY_MAX = 255 * DELAY_UNIT;
    localparam int CNT_MAX = (POWERUP_CYC > GAP_CYC)
                             ? ((POWERUP_CYC > DLY_MAX) ? POWERUP_CYC : DLY_MAX)
                             : ((GAP_CYC > DLY_MAX) ? GAP_CYC : DLY_MAX);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // Index carries one extra bit so reaching NUM_REGS is visible without wrapping.
    localparam logic [IDX_W:0] IDX_END = (IDX_W+1)'(NUM_REGS);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W:0]   idx_q, idx_d, idx_inc;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;

    assign idx_inc = idx_q + (IDX_W+1)'(1);

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_idx_d = err_idx_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_PWRUP;
                    cnt_d   = CNT_W'(POWERUP_CYC - 1);
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            S_PWRUP: begin
                if (cnt_q == '0) state_d = S_FETCH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_FETCH: begin
                if (tbl_addr_i == 8'hFF && tbl_data_i == 8'hFF) begin
                    state_d = S_DONE;
                end else if (tbl_addr_i == 8'hFE) begin
                    if (tbl_data_i == 8'h00) begin
                        // Zero-length delay: skip straight to the next entry.
                        idx_d   = idx_inc;
                        state_d = (idx_inc == IDX_END) ? S_DONE : S_FETCH;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = CNT_W'(tbl_data_i) * CNT_W'(DELAY_UNIT) - CNT_W'(1);
                    end
                end else begin
                    addr_d  = tbl_addr_i;
                    data_d  = tbl_data_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (xfer_done_i) begin
                    if (!xfer_nack_i) begin
                        retry_d = '0;
                        idx_d   = idx_inc;
                        state_d = S_GAP;
                        cnt_d   = CNT_W'(GAP_CYC - 1);
                    end else if (retry_q == RTY_W'(MAX_RETRY)) begin
                        err_idx_d = idx_q[IDX_W-1:0];
                        state_d   = S_ERR;
                    end else begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_GAP;
                        cnt_d   = CNT_W'(GAP_CYC - 1);
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = (idx_q == IDX_END) ? S_DONE : S_FETCH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == IDX_END) ? S_DONE : S_FETCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign tbl_index_o = idx_q[IDX_W-1:0];
    assign req_valid_o = (state_q == S_ISSUE);
    assign req_id_o    = DEV_ID;
    assign req_addr_o  = addr_q;
    assign req_data_o  = data_q;
    assign busy_o      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign init_done_o = (state_q == S_DONE);
    assign init_err_o  = (state_q == S_ERR);
    assign err_index_o = err_idx_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboard bench for sccb_init_sequencer: a table-walk model predicts every SCCB write,
// a monitor checks each accepted request, and a master model answers with ACK/NACK.
module tb_sccb_init_sequencer;

    localparam int         NREG = 8;
    localparam int         IW   = 3;
    localparam int         PWR  = 40;
    localparam int         GAPC = 6;
    localparam int         DU   = 8;
    localparam int         MR   = 3;
    localparam logic [7:0] DEV  = 8'h42;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          req_ready = 1'b0;
    logic          xfer_done = 1'b0;
    logic          xfer_nack = 1'b0;
    logic [IW-1:0] tbl_index, err_index;
    logic [7:0]    tbl_addr, tbl_data, req_id, req_addr, req_data;
    logic          req_valid, busy, init_done, init_err;

    logic [7:0] tab_a [NREG];
    logic [7:0] tab_d [NREG];
    assign tbl_addr = tab_a[tbl_index];
    assign tbl_data = tab_d[tbl_index];

    sccb_init_sequencer #(
        .DEV_ID(DEV), .NUM_REGS(NREG), .IDX_W(IW), .POWERUP_CYC(PWR),
        .GAP_CYC(GAPC), .DELAY_UNIT(DU), .MAX_RETRY(MR)
    ) dut (
        .pclk_i(clk), .preset_i(rst), .start_i(start),
        .tbl_index_o(tbl_index), .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data),
        .req_valid_o(req_valid), .req_ready_i(req_ready), .req_id_o(req_id),
        .req_addr_o(req_addr), .req_data_o(req_data),
        .xfer_done_i(xfer_done), .xfer_nack_i(xfer_nack),
        .busy_o(busy), .init_done_o(init_done), .init_err_o(init_err),
        .err_index_o(err_index)
    );

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t exp_q [$];
    int  acc_cyc [$];
    int  nack_cnt [NREG];
    int  issued [NREG];
    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  accepts = 0;
    int  done_timer = 0;
    bit  pend_nack = 0;
    bit  force_low = 0;
    bit  ready_rand = 0;
    bit  exp_done, exp_err;
    int  exp_eidx;
    bit  hold_v = 0;
    logic [15:0] hold_ad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: walk the table by its rules and list every write the master should see.
    function automatic void build_expect();
        int i = 0;
        exp_q.delete();
        exp_done = 1; exp_err = 0; exp_eidx = 0;
        while (i < NREG) begin
            if (tab_a[i] == 8'hFF && tab_d[i] == 8'hFF) return;
            if (tab_a[i] == 8'hFE) begin i++; continue; end
            if (nack_cnt[i] > MR) begin
                repeat (MR + 1) exp_q.push_back(wr_t'({tab_a[i], tab_d[i]}));
                exp_done = 0; exp_err = 1; exp_eidx = i;
                return;
            end
            repeat (nack_cnt[i] + 1) exp_q.push_back(wr_t'({tab_a[i], tab_d[i]}));
            i++;
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every accepted request against the scoreboard and checks hold stability.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("hold_valid", req_valid, 1);
                check("hold_addr_data", {req_addr, req_data}, hold_ad);
            end
            hold_v  = req_valid && !req_ready;
            hold_ad = {req_addr, req_data};
            if (req_valid && req_ready) begin
                accepts++;
                acc_cyc.push_back(cyc);
                check("req_id", req_id, DEV);
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("write_addr_data", {req_addr, req_data}, e);
                end
            end
        end
    end

    // SCCB master model: random ready, done pulse 1..4 cycles after accept, NACK per entry budget.
    always begin
        bit hs;
        int hidx;
        @(negedge clk);
        hs   = req_valid && req_ready && !rst;
        hidx = int'(tbl_index);
        @(posedge clk);
        #1;
        xfer_done = 0;
        xfer_nack = 0;
        if (rst) begin
            done_timer = 0;
        end else begin
            if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) begin
                    xfer_done = 1;
                    xfer_nack = pend_nack;
                end
            end
            if (hs) begin
                pend_nack  = issued[hidx] < nack_cnt[hidx];
                issued[hidx]++;
                done_timer = $urandom_range(1, 4);
            end
        end
        req_ready = force_low ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    task automatic clear_nacks();
        for (int i = 0; i < NREG; i++) begin nack_cnt[i] = 0; issued[i] = 0; end
    endtask

    task automatic fill_table(input int end_pos);
        for (int i = 0; i < NREG; i++) begin
            tab_a[i] = 8'($urandom_range(0, 8'hFD));
            tab_d[i] = 8'($urandom_range(0, 255));
        end
        if (end_pos < NREG) begin tab_a[end_pos] = 8'hFF; tab_d[end_pos] = 8'hFF; end
    endtask

    task automatic start_seq(input string name, output int t0);
        build_expect();
        accepts = 0;
        acc_cyc.delete();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        t0 = cyc;
        @(negedge clk);
        check({name, " busy_after_start"}, busy, 1);
        check({name, " done_cleared"}, {init_done, init_err}, 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!req_valid && n < 500) begin @(negedge clk); n++; end
        check({name, " valid_seen"}, req_valid, 1);
    endtask

    task automatic finish_seq(input string name);
        int n = 0;
        while (!(init_done || init_err) && n < 20000) begin @(negedge clk); n++; end
        check({name, " finished"}, n < 20000, 1);
        check({name, " init_done"}, init_done, exp_done);
        check({name, " init_err"}, init_err, exp_err);
        check({name, " busy_idle"}, busy, 0);
        check({name, " all_writes_seen"}, exp_q.size(), 0);
        if (exp_err) check({name, " err_index"}, err_index, exp_eidx);
    endtask

    initial begin
        int t0;
        clear_nacks();
        fill_table(NREG);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_valid", req_valid, 0);
        check("reset busy", busy, 0);
        check("reset flags", {init_done, init_err}, 0);
        check("reset index", tbl_index, 0);
        check("reset req_addr_data", {req_addr, req_data}, 0);
        check("reset err_index", err_index, 0);
        @(posedge clk); #1 rst = 0;

        // Delay entry between two writes.
        tab_a[0] = 8'h12; tab_d[0] = 8'h80;
        tab_a[1] = 8'hFE; tab_d[1] = 8'h02;
        tab_a[2] = 8'h11; tab_d[2] = 8'h01;
        tab_a[3] = 8'hFF; tab_d[3] = 8'hFF;
        start_seq("delay", t0);
        finish_seq("delay");
        check("delay write_count", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2)
            check("delay spacing", (acc_cyc[1] - acc_cyc[0]) >= 2 * DU + GAPC, 1);

        // Master holds off for 10 cycles.
        tab_a[0] = 8'h33; tab_d[0] = 8'h44;
        tab_a[1] = 8'hFF; tab_d[1] = 8'hFF;
        force_low = 1;
        start_seq("hold", t0);
        wait_valid("hold");
        repeat (10) @(negedge clk);
        check("hold still_valid", req_valid, 1);
        check("hold payload", {req_addr, req_data}, 16'h3344);
        check("hold no_accept", accepts, 0);
        force_low = 0;
        finish_seq("hold");
        check("hold one_accept", accepts, 1);

        // Entry 5 NACKed twice then ACKed.
        clear_nacks();
        fill_table(7);
        nack_cnt[5] = 2;
        start_seq("retry", t0);
        finish_seq("retry");
        check("retry entry5_issues", issued[5], 3);

        // Entry 2 always NACKed.
        clear_nacks();
        fill_table(NREG);
        nack_cnt[2] = 99;
        start_seq("abort", t0);
        finish_seq("abort");
        check("abort entry2_issues", issued[2], MR + 1);

        // No end marker: stops after NREG writes.
        clear_nacks();
        fill_table(NREG);
        start_seq("noend", t0);
        finish_seq("noend");
        check("noend writes", accepts, NREG);

        // Reset while a request is outstanding, then restart.
        clear_nacks();
        fill_table(3);
        force_low = 1;
        start_seq("midrst", t0);
        wait_valid("midrst");
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        @(negedge clk);
        check("midrst req_valid", req_valid, 0);
        check("midrst busy", busy, 0);
        check("midrst index", tbl_index, 0);
        check("midrst req_addr_data", {req_addr, req_data}, 0);
        @(posedge clk); #1 rst = 0;
        force_low = 0;
        clear_nacks();
        start_seq("restart", t0);
        finish_seq("restart");
        check("restart first_write_after_pwrup", (acc_cyc.size() > 0) && (acc_cyc[0] - t0 >= PWR), 1);

        // Randomised tables, delays, NACKs and ready back-pressure.
        ready_rand = 1;
        for (int r = 0; r < 6; r++) begin
            clear_nacks();
            fill_table($urandom_range(1, NREG));
            for (int i = 0; i < NREG; i++) begin
                if (tab_a[i] != 8'hFF && $urandom_range(0, 5) == 0) begin
                    tab_a[i] = 8'hFE;
                    tab_d[i] = 8'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 4) == 0) nack_cnt[i] = $urandom_range(1, MR + 1);
            end
            start_seq("random", t0);
            finish_seq("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
